// File: rtl/desc_feeder_pkg.sv
// Shared types and sizing for the descriptor feeder.
// Four pixel bytes pack into one 32-bit descriptor word.
package desc_feeder_pkg;

  localparam int PIX_PER_WORD   = 4;
  localparam int WORDS_PER_DESC = 64;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_SEND,
    OUT_GAP
  } out_state_e;

endpackage

// File: rtl/desc_word_fifo.sv
// Small FIFO of packed descriptor words.
// The head word is visible on dout whenever the FIFO is non-empty.
module desc_word_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rd];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/desc_feeder.sv
// Packs a pixel byte stream into 32-bit descriptor words and strobes
// them to the NCC descriptor port at most once every two cycles.
module desc_feeder
  import desc_feeder_pkg::*;
#(
  parameter int NUM_PIXELS = PIX_PER_WORD * WORDS_PER_DESC,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic [31:0] desc_data_out,
  output logic        desc_data_ready,
  output logic        busy,
  output logic        desc_done
);

  localparam int NUM_WORDS = NUM_PIXELS / PIX_PER_WORD;
  localparam int PCW = $clog2(NUM_PIXELS + 1);
  localparam int WCW = $clog2(NUM_WORDS + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  out_state_e       r_state;
  out_state_e       w_state_nxt;
  logic             r_busy;
  logic [PCW-1:0]   r_pix_cnt;
  logic [WCW-1:0]   r_strb_cnt;
  logic [1:0]       r_lane;
  logic [23:0]      r_buf;
  logic [31:0]      r_out;
  logic             w_ready;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_done;
  logic             w_full;
  logic             w_empty;
  logic [FCW-1:0]   w_fifo_cnt;
  logic [31:0]      w_head;

  // Stall only the word-completing byte on a full FIFO; a same-cycle pop
  // is deliberately not credited so the ready path stays shallow.
  assign w_ready  = r_busy & (r_pix_cnt < PCW'(NUM_PIXELS))
                  & ~((r_lane == 2'd3) & w_full);
  assign w_accept = pix_valid & w_ready;
  assign w_push   = w_accept & (r_lane == 2'd3);

  desc_word_fifo #(
    .W     (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   ({r_buf, pix_data}),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_fifo_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      OUT_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = OUT_SEND;
        end
      end
      OUT_SEND: w_state_nxt = OUT_GAP;
      OUT_GAP: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = OUT_SEND;
        end else begin
          w_state_nxt = OUT_IDLE;
        end
      end
      default: w_state_nxt = OUT_IDLE;
    endcase
  end

  assign w_done = (r_state == OUT_GAP) & (r_strb_cnt == WCW'(NUM_WORDS))
                & (w_fifo_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= OUT_IDLE;
      r_busy     <= 1'b0;
      r_pix_cnt  <= '0;
      r_strb_cnt <= '0;
      r_lane     <= '0;
      r_buf      <= '0;
      r_out      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_out <= w_head;
      if (start && !r_busy) begin
        r_busy     <= 1'b1;
        r_pix_cnt  <= '0;
        r_strb_cnt <= '0;
        r_lane     <= '0;
      end else begin
        if (w_done) r_busy <= 1'b0;
        if (w_accept) begin
          r_pix_cnt <= r_pix_cnt + 1'b1;
          r_lane    <= r_lane + 1'b1;
          r_buf     <= {r_buf[15:0], pix_data};
        end
        if (r_state == OUT_SEND && r_strb_cnt < WCW'(NUM_WORDS))
          r_strb_cnt <= r_strb_cnt + 1'b1;
      end
    end
  end

  assign pix_ready       = w_ready;
  assign desc_data_out   = r_out;
  assign desc_data_ready = (r_state == OUT_SEND);
  assign busy            = r_busy;
  assign desc_done       = w_done;

endmodule

// File: tb/tb_desc_feeder.sv
// Directed bench for desc_feeder: a vector table for the first word,
// then streaming, sparse, restart, reset and idle sequences.
module tb_desc_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic [31:0] desc_data_out;
  logic        desc_data_ready;
  logic        busy;
  logic        desc_done;

  desc_feeder dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .pix_valid       (pix_valid),
    .pix_data        (pix_data),
    .pix_ready       (pix_ready),
    .desc_data_out   (desc_data_out),
    .desc_data_ready (desc_data_ready),
    .busy            (busy),
    .desc_done       (desc_done)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int done_cnt = 0;
  logic [31:0] wq[$];
  int          sq[$];
  int          aq[$];
  logic [31:0] last_w;
  bit          have_last = 0;
  int          last_s = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Output monitor: records strobes, checks spacing and hold stability.
  always @(negedge clk) begin
    if (rst) begin
      have_last = 0;
    end else begin
      if (desc_data_ready) begin
        if (have_last) begin
          nchk++;
          if (cyc - last_s < 2) begin
            nerr++;
            $display("FAIL spacing: got %0d cycles want >=2", cyc - last_s);
          end
        end
        wq.push_back(desc_data_out);
        sq.push_back(cyc);
        last_s    = cyc;
        last_w    = desc_data_out;
        have_last = 1;
      end else if (have_last) begin
        chk("hold", desc_data_out, last_w);
      end
      if (desc_done) done_cnt++;
    end
  end

  function automatic logic [7:0] pix_of(input int i, input int m,
                                         input int a);
    pix_of = 8'((i * m + a) & 255);
  endfunction

  task automatic begin_xfer();
    wq.delete();
    sq.delete();
    aq.delete();
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int gap, input int restart_at,
                      input int abort_at, input int m, input int a,
                      input int max_stalls);
    int n;
    int stalls;
    stalls = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == abort_at) break;
      pix_valid = 1'b1;
      pix_data  = pix_of(i, m, a);
      start     = (i == restart_at);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!pix_ready && n < 50);
      if (!pix_ready) begin
        nchk++;
        nerr++;
        $display("FAIL accept_timeout: byte %0d not accepted", i);
        pix_valid = 1'b0;
        start = 1'b0;
        return;
      end
      if (n > 1) stalls++;
      if (i % 4 == 3) aq.push_back(cyc + 1);
      @(posedge clk); #1;
      pix_valid = 1'b0;
      start     = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    nchk++;
    if (stalls > max_stalls) begin
      nerr++;
      $display("FAIL stalls: got %0d want <=%0d", stalls, max_stalls);
    end
  endtask

  task automatic finish_xfer(input int m, input int a);
    int n;
    logic [31:0] w;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("strobe_count", 32'(wq.size()), 32'd64);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 64 && k < wq.size(); k++) begin
      w = {pix_of(4*k, m, a), pix_of(4*k+1, m, a),
           pix_of(4*k+2, m, a), pix_of(4*k+3, m, a)};
      chk($sformatf("word%0d", k), wq[k], w);
      if (k < aq.size() && k < sq.size())
        chk($sformatf("latency%0d", k), 32'(sq[k]), 32'(aq[k] + 1));
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pix_ready"}, {31'd0, pix_ready}, 32'd0);
    chk({tag, "_data_out"}, desc_data_out, 32'd0);
    chk({tag, "_data_ready"}, {31'd0, desc_data_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, desc_done}, 32'd0);
  endtask

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic        e_pr;
    logic        e_rdy;
    logic        e_busy;
    logic        e_done;
    logic [31:0] e_out;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[2] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[3] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[4] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[5] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vt[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11223344};
    vt[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11223344};
    vt[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11223344};

    rst = 1'b1;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int r = 0; r < 10; r++) begin
      start     = vt[r].st;
      pix_valid = vt[r].v;
      pix_data  = vt[r].d;
      @(negedge clk);
      chk($sformatf("v%0d_pix_ready", r), {31'd0, pix_ready},
          {31'd0, vt[r].e_pr});
      chk($sformatf("v%0d_data_ready", r), {31'd0, desc_data_ready},
          {31'd0, vt[r].e_rdy});
      chk($sformatf("v%0d_busy", r), {31'd0, busy}, {31'd0, vt[r].e_busy});
      chk($sformatf("v%0d_done", r), {31'd0, desc_done},
          {31'd0, vt[r].e_done});
      chk($sformatf("v%0d_data_out", r), desc_data_out, vt[r].e_out);
      @(posedge clk); #1;
    end
    start = 1'b0;
    pix_valid = 1'b0;

    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("vecrst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-rate stream 0x00..0xFF: the FIFO never fills, so no stalls.
    begin_xfer();
    feed(0, -1, -1, 1, 0, 0);
    finish_xfer(1, 0);
    if (wq.size() == 64) begin
      chk("stream_w0", wq[0], 32'h00010203);
      chk("stream_w63", wq[63], 32'hFCFDFEFF);
    end

    // Sparse: one byte every 7 cycles.
    begin_xfer();
    feed(6, -1, -1, 7, 3, 0);
    finish_xfer(7, 3);

    // Second start at word 10 must be ignored.
    begin_xfer();
    feed(0, 40, -1, 3, 5, 0);
    finish_xfer(3, 5);

    // Reset after 130 pixels, then a fresh transfer.
    begin_xfer();
    feed(0, -1, 130, 1, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    wq.delete();
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("no_strobe_after_rst", 32'(wq.size()), 32'd0);
    chk("idle_after_rst", {31'd0, busy}, 32'd0);
    begin_xfer();
    feed(1, -1, -1, 5, 9, 0);
    finish_xfer(5, 9);

    // Idle with pix_valid asserted and no start.
    pix_valid = 1'b1;
    pix_data  = 8'h5A;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle_pix_ready", {31'd0, pix_ready}, 32'd0);
      chk("idle_data_ready", {31'd0, desc_data_ready}, 32'd0);
    end
    pix_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
